// File: rtl/issue_queue_int_pkg.sv
// Shared definitions for the integer issue queue: ALU opcode encodings,
// default widths and the per-entry storage record.
package issue_queue_int_pkg;

  localparam int IQ_TAG_W  = 6;
  localparam int IQ_DATA_W = 32;

  localparam logic [2:0] OP_RTYPE  = 3'b000;
  localparam logic [2:0] OP_J      = 3'b001;
  localparam logic [2:0] OP_COPROC = 3'b010;
  localparam logic [2:0] OP_ITYPE  = 3'b011;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           opcode;
    logic [4:0]           shfamt;
    logic [15:0]          imm;
    logic [IQ_TAG_W-1:0]  rs_tag;
    logic [IQ_DATA_W-1:0] rs_data;
    logic                 rs_ready;
    logic [IQ_TAG_W-1:0]  rt_tag;
    logic [IQ_DATA_W-1:0] rt_data;
    logic                 rt_ready;
    logic [IQ_TAG_W-1:0]  rd_tag;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue_int_select.sv
// Priority encoder: reports whether any request is set and the lowest set index.
module int_issue_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan from the top so the lowest requesting index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue_int.sv
// Collapsing integer issue queue: CDB wakeup, oldest-ready select and
// valid/ready issue to the integer ALU.
module issue_queue_int
  import issue_queue_int_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Dispatch_en_integer,
  input  logic [2:0]        Dispatch_opcode,
  input  logic [4:0]        Dispatch_shfamt,
  input  logic [15:0]       Dispatch_imm,
  input  logic [TAG_W-1:0]  Dispatch_rs_tag,
  input  logic [TAG_W-1:0]  Dispatch_rt_tag,
  input  logic [DATA_W-1:0] Dispatch_rs_data,
  input  logic [DATA_W-1:0] Dispatch_rt_data,
  input  logic              Dispatch_rs_ready,
  input  logic              Dispatch_rt_ready,
  input  logic [TAG_W-1:0]  Dispatch_rd_tag,
  input  logic              Flush,
  input  logic              Cdb_valid,
  input  logic [TAG_W-1:0]  Cdb_tag,
  input  logic [DATA_W-1:0] Cdb_data,
  input  logic              Issue_int_ready,
  output logic              Issueque_int_full,
  output logic              Issue_int_valid,
  output logic [2:0]        Issue_int_opcode,
  output logic [4:0]        Issue_int_shfamt,
  output logic [15:0]       Issue_int_imm,
  output logic [DATA_W-1:0] Issue_int_rs_data,
  output logic [DATA_W-1:0] Issue_int_rt_data,
  output logic [TAG_W-1:0]  Issue_int_rd_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  iq_entry_t        q     [DEPTH];
  iq_entry_t        nq    [DEPTH];
  iq_entry_t        new_entry;
  iq_entry_t        sel;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] wr_idx;
  logic [DEPTH-1:0] req;
  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_fire;
  logic             disp_fire;

  function automatic iq_entry_t wake(input iq_entry_t e, input logic v,
                                     input logic [TAG_W-1:0] t,
                                     input logic [DATA_W-1:0] d);
    iq_entry_t r;
    r = e;
    if (v && e.valid && !e.rs_ready && e.rs_tag == t) begin
      r.rs_data  = d;
      r.rs_ready = 1'b1;
    end
    if (v && e.valid && !e.rt_ready && e.rt_tag == t) begin
      r.rt_data  = d;
      r.rt_ready = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      req[i] = q[i].valid && q[i].rs_ready && q[i].rt_ready;
  end

  int_issue_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .req   (req),
    .found (found),
    .idx   (sel_idx)
  );

  assign Issueque_int_full = (count == CNT_W'(DEPTH));
  assign issue_fire        = found && Issue_int_ready;
  assign disp_fire         = Dispatch_en_integer && !Issueque_int_full;
  assign wr_idx            = count - CNT_W'(issue_fire);
  assign count_nxt         = count + CNT_W'(disp_fire) - CNT_W'(issue_fire);

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.opcode   = Dispatch_opcode;
    new_entry.shfamt   = Dispatch_shfamt;
    new_entry.imm      = Dispatch_imm;
    new_entry.rs_tag   = Dispatch_rs_tag;
    new_entry.rs_data  = Dispatch_rs_data;
    new_entry.rs_ready = Dispatch_rs_ready;
    new_entry.rt_tag   = Dispatch_rt_tag;
    new_entry.rt_data  = Dispatch_rt_data;
    new_entry.rt_ready = Dispatch_rt_ready;
    new_entry.rd_tag   = Dispatch_rd_tag;
    // The broadcast in the dispatch cycle must not be missed by the new entry.
    new_entry          = wake(new_entry, Cdb_valid, Cdb_tag, Cdb_data);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      nq[i] = wake(q[i], Cdb_valid, Cdb_tag, Cdb_data);
    if (issue_fire) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (IDX_W'(i) >= sel_idx) nq[i] = nq[i+1];
      nq[DEPTH-1].valid = 1'b0;
    end
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == CNT_W'(i)) nq[i] = new_entry;
    end
  end

  // Queue state register; only occupancy is cleared, payload fields are don't-care.
  always_ff @(posedge clock) begin
    if (reset || Flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      count <= '0;
    end else begin
      q     <= nq;
      count <= count_nxt;
    end
  end

  assign sel               = q[sel_idx];
  assign Issue_int_valid   = found;
  assign Issue_int_opcode  = found ? sel.opcode  : '0;
  assign Issue_int_shfamt  = found ? sel.shfamt  : '0;
  assign Issue_int_imm     = found ? sel.imm     : '0;
  assign Issue_int_rs_data = found ? sel.rs_data : '0;
  assign Issue_int_rt_data = found ? sel.rt_data : '0;
  assign Issue_int_rd_tag  = found ? sel.rd_tag  : '0;

endmodule

// File: tb/tb_issue_queue_int.sv
// Self-checking bench for issue_queue_int: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_issue_queue_int;
  import issue_queue_int_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 6;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset, Dispatch_en_integer, Flush, Cdb_valid, Issue_int_ready;
  logic [2:0]    Dispatch_opcode;
  logic [4:0]    Dispatch_shfamt;
  logic [15:0]   Dispatch_imm;
  logic [TW-1:0] Dispatch_rs_tag, Dispatch_rt_tag, Dispatch_rd_tag, Cdb_tag;
  logic [DW-1:0] Dispatch_rs_data, Dispatch_rt_data, Cdb_data;
  logic          Dispatch_rs_ready, Dispatch_rt_ready;
  logic          Issueque_int_full, Issue_int_valid;
  logic [2:0]    Issue_int_opcode;
  logic [4:0]    Issue_int_shfamt;
  logic [15:0]   Issue_int_imm;
  logic [DW-1:0] Issue_int_rs_data, Issue_int_rt_data;
  logic [TW-1:0] Issue_int_rd_tag;

  issue_queue_int #(.DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .Dispatch_en_integer(Dispatch_en_integer), .Dispatch_opcode(Dispatch_opcode),
    .Dispatch_shfamt(Dispatch_shfamt), .Dispatch_imm(Dispatch_imm),
    .Dispatch_rs_tag(Dispatch_rs_tag), .Dispatch_rt_tag(Dispatch_rt_tag),
    .Dispatch_rs_data(Dispatch_rs_data), .Dispatch_rt_data(Dispatch_rt_data),
    .Dispatch_rs_ready(Dispatch_rs_ready), .Dispatch_rt_ready(Dispatch_rt_ready),
    .Dispatch_rd_tag(Dispatch_rd_tag), .Flush(Flush),
    .Cdb_valid(Cdb_valid), .Cdb_tag(Cdb_tag), .Cdb_data(Cdb_data),
    .Issue_int_ready(Issue_int_ready), .Issueque_int_full(Issueque_int_full),
    .Issue_int_valid(Issue_int_valid), .Issue_int_opcode(Issue_int_opcode),
    .Issue_int_shfamt(Issue_int_shfamt), .Issue_int_imm(Issue_int_imm),
    .Issue_int_rs_data(Issue_int_rs_data), .Issue_int_rt_data(Issue_int_rt_data),
    .Issue_int_rd_tag(Issue_int_rd_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    op;
    logic [4:0]    sh;
    logic [15:0]   imm;
    logic [TW-1:0] rs_tag, rt_tag, rd;
    logic [DW-1:0] rs_d, rt_d;
    bit            rs_r, rt_r;
  } mentry_t;

  mentry_t mq[$];
  int      checks   = 0;
  int      failures = 0;
  bit      chk_en   = 1'b0;
  logic [2:0] ops [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: ordered list of waiting instructions, oldest first.
  task automatic model_step();
    int      s;
    bit      fire;
    mentry_t n;
    if (reset || Flush) begin
      mq.delete();
      return;
    end
    s = -1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].rs_r && mq[i].rt_r) begin s = i; break; end
    fire = (s >= 0) && Issue_int_ready;
    if (Cdb_valid)
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].rs_r && mq[i].rs_tag == Cdb_tag) begin mq[i].rs_r = 1; mq[i].rs_d = Cdb_data; end
        if (!mq[i].rt_r && mq[i].rt_tag == Cdb_tag) begin mq[i].rt_r = 1; mq[i].rt_d = Cdb_data; end
      end
    if (Dispatch_en_integer && mq.size() < DEPTH) begin
      n.op = Dispatch_opcode; n.sh = Dispatch_shfamt; n.imm = Dispatch_imm;
      n.rs_tag = Dispatch_rs_tag; n.rt_tag = Dispatch_rt_tag; n.rd = Dispatch_rd_tag;
      n.rs_r = Dispatch_rs_ready; n.rs_d = Dispatch_rs_ready ? Dispatch_rs_data : '0;
      n.rt_r = Dispatch_rt_ready; n.rt_d = Dispatch_rt_ready ? Dispatch_rt_data : '0;
      if (!n.rs_r && Cdb_valid && Cdb_tag == n.rs_tag) begin n.rs_r = 1; n.rs_d = Cdb_data; end
      if (!n.rt_r && Cdb_valid && Cdb_tag == n.rt_tag) begin n.rt_r = 1; n.rt_d = Cdb_data; end
    end
    if (fire) mq.delete(s);
    if (Dispatch_en_integer && mq.size() + (fire ? 1 : 0) < DEPTH) mq.push_back(n);
  endtask

  always @(negedge clock) begin
    int s;
    logic [127:0] exp_p, act_p;
    if (chk_en) begin
      s = -1;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].rs_r && mq[i].rt_r) begin s = i; break; end
      chk("model_full", Issueque_int_full, mq.size() == DEPTH);
      chk("model_valid", Issue_int_valid, s >= 0);
      exp_p = '0;
      if (s >= 0)
        exp_p = {mq[s].op, mq[s].sh, mq[s].imm, mq[s].rs_d, mq[s].rt_d, mq[s].rd};
      act_p = {Issue_int_opcode, Issue_int_shfamt, Issue_int_imm,
               Issue_int_rs_data, Issue_int_rt_data, Issue_int_rd_tag};
      chk("model_payload", act_p, exp_p);
    end
  end

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 0; Flush = 0; Dispatch_en_integer = 0; Cdb_valid = 0; Cdb_tag = '0;
    Cdb_data = '0; Issue_int_ready = 0; Dispatch_opcode = OP_ITYPE; Dispatch_shfamt = 5'd3;
    Dispatch_imm = '0; Dispatch_rs_tag = '0; Dispatch_rt_tag = '0; Dispatch_rd_tag = 6'd9;
    Dispatch_rs_data = 32'h11; Dispatch_rt_data = 32'h22;
    Dispatch_rs_ready = 1; Dispatch_rt_ready = 1;
  endtask

  task automatic disp(input logic [15:0] imm, input logic [TW-1:0] rs_tag, input logic rs_rdy);
    Dispatch_en_integer = 1; Dispatch_imm = imm;
    Dispatch_rs_tag = rs_tag; Dispatch_rs_ready = rs_rdy; Dispatch_rt_ready = 1;
  endtask

  initial begin
    ops[0] = OP_RTYPE; ops[1] = OP_J; ops[2] = OP_COPROC; ops[3] = OP_ITYPE;
    idle();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    chk_en = 1;
    chk("rst_valid", Issue_int_valid, 0);
    chk("rst_full", Issueque_int_full, 0);
    chk("rst_imm", Issue_int_imm, 0);

    // Single ready instruction issues the cycle after dispatch.
    Issue_int_ready = 1; disp(16'h0010, 0, 1);
    cyc(); Dispatch_en_integer = 0;
    chk("t1_valid", Issue_int_valid, 1);
    chk("t1_imm", Issue_int_imm, 16'h0010);
    chk("t1_op", Issue_int_opcode, 3'b011);
    cyc();
    chk("t1_empty", Issue_int_valid, 0);

    // Fill with the consumer stalled, overflow the fifth, drain in order.
    Issue_int_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      disp(16'(k), 0, 1);
      cyc();
      if (k == 4) chk("t2_full4", Issueque_int_full, 1);
    end
    Dispatch_en_integer = 0;
    chk("t2_full5", Issueque_int_full, 1);
    Issue_int_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("t2_order", Issue_int_imm, 16'(k));
      cyc();
    end
    chk("t2_drained", Issue_int_valid, 0);
    chk("t2_notfull", Issueque_int_full, 0);

    // Wakeup via CDB.
    Issue_int_ready = 0; disp(16'h0003, 6'd5, 0);
    cyc(); Dispatch_en_integer = 0;
    chk("t3_wait", Issue_int_valid, 0);
    Cdb_valid = 1; Cdb_tag = 6'd5; Cdb_data = 32'hDEADBEEF;
    cyc(); Cdb_valid = 0;
    chk("t3_valid", Issue_int_valid, 1);
    chk("t3_rs", Issue_int_rs_data, 32'hDEADBEEF);
    Issue_int_ready = 1; cyc();
    chk("t3_drained", Issue_int_valid, 0);

    // Younger ready entry overtakes an older waiting one.
    disp(16'h000A, 6'd3, 0); cyc();
    disp(16'h000B, 6'd1, 1); cyc(); Dispatch_en_integer = 0;
    chk("t4_b_first", Issue_int_imm, 16'h000B);
    cyc();
    chk("t4_a_waits", Issue_int_valid, 0);
    Cdb_valid = 1; Cdb_tag = 6'd3; Cdb_data = 32'h0000_0A0A;
    cyc(); Cdb_valid = 0;
    chk("t4_a_imm", Issue_int_imm, 16'h000A);
    chk("t4_a_rs", Issue_int_rs_data, 32'h0000_0A0A);
    cyc();
    chk("t4_drained", Issue_int_valid, 0);

    // Dispatch-cycle bypass.
    Issue_int_ready = 0; disp(16'h0005, 6'd7, 0);
    Cdb_valid = 1; Cdb_tag = 6'd7; Cdb_data = 32'h00001234;
    cyc(); Cdb_valid = 0; Dispatch_en_integer = 0;
    chk("t5_valid", Issue_int_valid, 1);
    chk("t5_rs", Issue_int_rs_data, 32'h00001234);
    Issue_int_ready = 1; cyc();

    // Flush with entries held and a concurrent dispatch.
    Issue_int_ready = 0;
    for (int k = 0; k < 3; k++) begin disp(16'(k + 20), 0, 1); cyc(); end
    chk("t6_pre", Issue_int_valid, 1);
    Flush = 1; cyc(); Flush = 0; Dispatch_en_integer = 0;
    chk("t6_valid", Issue_int_valid, 0);
    chk("t6_full", Issueque_int_full, 0);
    chk("t6_imm", Issue_int_imm, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset               = ($urandom_range(0, 199) == 0);
      Flush               = ($urandom_range(0, 59) == 0);
      Dispatch_en_integer = ($urandom_range(0, 99) < 55);
      Dispatch_opcode     = ops[$urandom_range(0, 3)];
      Dispatch_shfamt     = 5'($urandom);
      Dispatch_imm        = 16'($urandom);
      Dispatch_rs_tag     = 6'($urandom_range(0, 7));
      Dispatch_rt_tag     = 6'($urandom_range(0, 7));
      Dispatch_rd_tag     = 6'($urandom);
      Dispatch_rs_data    = $urandom;
      Dispatch_rt_data    = $urandom;
      Dispatch_rs_ready   = ($urandom_range(0, 99) < 50);
      Dispatch_rt_ready   = ($urandom_range(0, 99) < 60);
      Cdb_valid           = ($urandom_range(0, 99) < 45);
      Cdb_tag             = 6'($urandom_range(0, 7));
      Cdb_data            = $urandom;
      Issue_int_ready     = ($urandom_range(0, 99) < 55);
      cyc();
    end
    idle();
    cyc();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
